// File: rtl/ex_muldiv_if.sv
// Execute-stage multiply/divide handshake: request from the pipeline, registered
// result presented back to the memory-access stage.
interface ex_muldiv_if #(
  parameter int XLEN = 64
);
  logic            EN;
  logic            KILL;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [4:0]      rd_i;
  logic            write_back;
  logic [XLEN-1:0] res;
  logic [4:0]      rd_o;
  logic            write_back_o;
  logic            stall;
  logic            done;

  modport master (
    output EN, KILL, op, rs1, rs2, rd_i, write_back,
    input  res, rd_o, write_back_o, stall, done
  );

  modport slave (
    input  EN, KILL, op, rs1, rs2, rd_i, write_back,
    output res, rd_o, write_back_o, stall, done
  );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative RV64M multiply/divide: one operation at a time, one bit per cycle,
// with single-cycle fast paths for divide-by-zero and signed overflow.
module ex_muldiv #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic        CLK,
  input  logic        RST_N,
  ex_muldiv_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  op_e               op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic              wb_q, wb_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   acc_hi_q, acc_hi_d;
  logic [XLEN-1:0]   acc_lo_q, acc_lo_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic [4:0]        rd_o_q, rd_o_d;
  logic              wb_o_q, wb_o_d;
  logic              done_q, done_d;

  // Request decode
  op_e             op_in;
  logic            in_is_div;
  logic            a_signed, b_signed;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            in_res_neg;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] fast_res;

  always_comb begin
    op_in      = op_e'(bus.op);
    in_is_div  = bus.op[2];
    a_signed   = op_in inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    b_signed   = op_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    a_neg      = a_signed & bus.rs1[XLEN-1];
    b_neg      = b_signed & bus.rs2[XLEN-1];
    a_mag      = a_neg ? -bus.rs1 : bus.rs1;
    b_mag      = b_neg ? -bus.rs2 : bus.rs2;
    // The remainder follows the dividend; everything else follows the operand signs.
    in_res_neg = (op_in == OP_REM) ? a_neg : (a_neg ^ b_neg);
    div_zero   = in_is_div && (bus.rs2 == '0);
    div_ovf    = (op_in inside {OP_DIV, OP_REM}) &&
                 (bus.rs1 == MIN_NEG) && (bus.rs2 == ALL_ONE);
    fast_res   = '0;
    if (div_zero) begin
      fast_res = (op_in inside {OP_DIV, OP_DIVU}) ? ALL_ONE : bus.rs1;
    end else if (div_ovf) begin
      fast_res = (op_in == OP_DIV) ? MIN_NEG : '0;
    end
  end

  // One iteration of each datapath; only the one matching op_q is committed.
  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   mul_hi_n, mul_lo_n;
  logic [XLEN:0]     div_shift, div_diff;
  logic              div_ge;
  logic [XLEN-1:0]   div_hi_n, div_lo_n;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s;
  logic [XLEN-1:0]   final_res;

  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
    mul_hi_n  = mul_sum[XLEN:1];
    mul_lo_n  = {mul_sum[0], acc_lo_q[XLEN-1:1]};

    // Restoring step: partial remainder is always below the divisor, so the
    // shifted value fits XLEN+1 bits and the top bit of the difference is the borrow.
    div_shift = {acc_hi_q, acc_lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    div_ge    = ~div_diff[XLEN];
    div_hi_n  = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
    div_lo_n  = {acc_lo_q[XLEN-2:0], div_ge};

    prod_s    = neg_q ? -{mul_hi_n, mul_lo_n} : {mul_hi_n, mul_lo_n};
    quo_s     = neg_q ? -div_lo_n : div_lo_n;
    rem_s     = neg_q ? -div_hi_n : div_hi_n;

    unique case (op_q)
      OP_MUL:                        final_res = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  final_res = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               final_res = quo_s;
      default:                       final_res = rem_s;
    endcase
  end

  always_comb begin
    // NOTE: every next-state signal takes its hold value first so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    rd_d     = rd_q;
    wb_d     = wb_q;
    neg_d    = neg_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opb_d    = opb_q;
    res_d    = res_q;
    rd_o_d   = rd_o_q;
    wb_o_d   = 1'b0;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.EN && !bus.KILL) begin
          op_d = op_in;
          rd_d = bus.rd_i;
          wb_d = bus.write_back;
          if (div_zero || div_ovf) begin
            res_d   = fast_res;
            rd_o_d  = bus.rd_i;
            wb_o_d  = bus.write_back;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            neg_d    = in_res_neg;
            acc_hi_d = '0;
            // Divide: dividend shifts out of the low half as quotient bits shift in.
            // Multiply: multiplier shifts out of the low half as product bits shift in.
            acc_lo_d = in_is_div ? a_mag : b_mag;
            opb_d    = in_is_div ? b_mag : a_mag;
            cnt_d    = CNT_W'(XLEN);
            state_d  = S_BUSY;
          end
        end
      end

      S_BUSY: begin
        if (bus.KILL) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          acc_hi_d = op_q[2] ? div_hi_n : mul_hi_n;
          acc_lo_d = op_q[2] ? div_lo_n : mul_lo_n;
          cnt_d    = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            res_d   = final_res;
            rd_o_d  = rd_q;
            wb_o_d  = wb_q;
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples the
  // pre-edge value of every other flop.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_MUL;
      rd_q     <= '0;
      wb_q     <= 1'b0;
      neg_q    <= 1'b0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opb_q    <= '0;
      res_q    <= '0;
      rd_o_q   <= '0;
      wb_o_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      wb_q     <= wb_d;
      neg_q    <= neg_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opb_q    <= opb_d;
      res_q    <= res_d;
      rd_o_q   <= rd_o_d;
      wb_o_q   <= wb_o_d;
      done_q   <= done_d;
    end
  end

  // A flush arriving in the DONE cycle cancels the write-back but not the pulse.
  assign bus.res          = res_q;
  assign bus.rd_o         = rd_o_q;
  assign bus.write_back_o = wb_o_q & ~bus.KILL;
  assign bus.stall        = (state_q == S_BUSY);
  assign bus.done         = done_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: expected results come from plain 128-bit and
// signed arithmetic; a monitor pops and compares on every done pulse.
module tb_ex_muldiv;

  localparam logic [63:0] MIN_NEG = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ALL_ONE = 64'hFFFF_FFFF_FFFF_FFFF;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  ex_muldiv_if bus ();

  ex_muldiv dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [63:0] res;
    logic [4:0]  rd;
    logic        wb;
    int          stalls;
  } exp_t;

  exp_t        sb_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [63:0] last_res = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] sa, sb, ua, ub;
    logic [127:0] p;
    sa = {{64{a[63]}}, a};
    sb = {{64{b[63]}}, b};
    ua = {64'b0, a};
    ub = {64'b0, b};
    case (op)
      3'd0: begin p = ua * ub; return p[63:0];   end
      3'd1: begin p = sa * sb; return p[127:64]; end
      3'd2: begin p = sa * ub; return p[127:64]; end
      3'd3: begin p = ua * ub; return p[127:64]; end
      3'd4: begin
        if (b == 0) return ALL_ONE;
        if (a == MIN_NEG && b == ALL_ONE) return MIN_NEG;
        return $signed(a) / $signed(b);
      end
      3'd5: begin
        if (b == 0) return ALL_ONE;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN_NEG && b == ALL_ONE) return 64'd0;
        return $signed(a) % $signed(b);
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int exp_stalls(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    if (op[2] && b == 0) return 0;
    if ((op == 3'd4 || op == 3'd6) && a == MIN_NEG && b == ALL_ONE) return 0;
    return 64;
  endfunction

  // Monitor: compares every done pulse against the head of the scoreboard and
  // counts the stall cycles that led up to it.
  initial begin
    int   stall_cnt;
    exp_t e;
    stall_cnt = 0;
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        stall_cnt = 0;
      end else if (bus.done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", bus.done, 1'b0);
        end else begin
          e = sb_q.pop_front();
          check("res", bus.res, e.res);
          check("rd_o", bus.rd_o, e.rd);
          check("write_back_o", bus.write_back_o, e.wb);
          check("stall_cycles", stall_cnt, e.stalls);
        end
        stall_cnt = 0;
      end else begin
        if (bus.write_back_o) check("wb_outside_done", bus.write_back_o, 1'b0);
        stall_cnt = bus.stall ? stall_cnt + 1 : 0;
      end
    end
  end

  task automatic drive(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] rd, input logic wb);
    bus.op = op; bus.rs1 = a; bus.rs2 = b; bus.rd_i = rd; bus.write_back = wb;
  endtask

  task automatic push_exp(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] rd, input logic wb);
    exp_t e;
    e.res = model(op, a, b); e.rd = rd; e.wb = wb; e.stalls = exp_stalls(op, a, b);
    sb_q.push_back(e);
    last_res = e.res;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(posedge CLK);
    check("drain_timeout", sb_q.size(), 0);
    sb_q.delete();
    @(posedge CLK);
  endtask

  task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] rd, input logic wb);
    @(posedge CLK); #1;
    drive(op, a, b, rd, wb);
    push_exp(op, a, b, rd, wb);
    bus.EN = 1'b1;
    @(posedge CLK); #1;
    bus.EN = 1'b0;
    wait_drain();
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return ALL_ONE;
      2:       return MIN_NEG;
      3:       return 64'($urandom_range(0, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    bus.EN = 1'b0; bus.KILL = 1'b0;
    drive(3'd0, '0, '0, '0, 1'b0);
    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_res", bus.res, 64'd0);
    check("rst_rd_o", bus.rd_o, 5'd0);
    check("rst_wb_o", bus.write_back_o, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_stall", bus.stall, 1'b0);
    RST_N = 1'b1;

    // Reset in the middle of DIVU 100/7 discards the partial result.
    @(posedge CLK); #1;
    drive(3'd5, 64'd100, 64'd7, 5'd3, 1'b1);
    bus.EN = 1'b1;
    @(posedge CLK); #1;
    bus.EN = 1'b0;
    repeat (29) @(posedge CLK);
    #1;
    check("pre_reset_stall", bus.stall, 1'b1);
    RST_N = 1'b0;
    #1;
    check("midrst_stall", bus.stall, 1'b0);
    check("midrst_res", bus.res, 64'd0);
    check("midrst_done", bus.done, 1'b0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    last_res = '0;

    // Directed cases
    issue(3'd5, 64'd100, 64'd7, 5'd3, 1'b1);
    issue(3'd0, ALL_ONE, 64'd3, 5'd7, 1'b1);
    issue(3'd3, ALL_ONE, ALL_ONE, 5'd8, 1'b1);
    issue(3'd1, ALL_ONE, ALL_ONE, 5'd9, 1'b0);
    issue(3'd2, ALL_ONE, ALL_ONE, 5'd10, 1'b1);
    issue(3'd4, -64'sd7, 64'd2, 5'd11, 1'b1);
    issue(3'd6, -64'sd7, 64'd2, 5'd12, 1'b1);
    issue(3'd5, 64'd55, 64'd0, 5'd13, 1'b1);
    issue(3'd7, 64'd55, 64'd0, 5'd14, 1'b1);
    issue(3'd4, MIN_NEG, ALL_ONE, 5'd15, 1'b1);
    issue(3'd6, MIN_NEG, ALL_ONE, 5'd16, 1'b1);

    // KILL during BUSY cycle 10: back to IDLE, no pulse, res unchanged.
    @(posedge CLK); #1;
    drive(3'd0, 64'd12345, 64'd678, 5'd17, 1'b1);
    bus.EN = 1'b1;
    @(posedge CLK); #1;
    bus.EN = 1'b0;
    repeat (9) @(posedge CLK);
    #1;
    bus.KILL = 1'b1;
    @(posedge CLK); #1;
    bus.KILL = 1'b0;
    check("kill_busy_stall", bus.stall, 1'b0);
    check("kill_busy_done", bus.done, 1'b0);
    check("kill_busy_res_hold", bus.res, last_res);
    repeat (80) @(posedge CLK);

    // KILL with EN in IDLE suppresses the start, even on the fast path.
    @(posedge CLK); #1;
    drive(3'd5, 64'd9, 64'd0, 5'd18, 1'b1);
    bus.EN = 1'b1; bus.KILL = 1'b1;
    @(posedge CLK); #1;
    bus.EN = 1'b0; bus.KILL = 1'b0;
    check("kill_idle_stall", bus.stall, 1'b0);
    check("kill_idle_done", bus.done, 1'b0);
    repeat (5) @(posedge CLK);

    // KILL in the DONE cycle: pulse completes, write-back suppressed.
    @(posedge CLK); #1;
    drive(3'd5, 64'd9, 64'd0, 5'd19, 1'b1);
    push_exp(3'd5, 64'd9, 64'd0, 5'd19, 1'b0);
    bus.EN = 1'b1;
    @(posedge CLK); #1;
    bus.EN = 1'b0; bus.KILL = 1'b1;
    @(posedge CLK); #1;
    bus.KILL = 1'b0;
    wait_drain();

    // EN held through BUSY and DONE yields a single completion.
    @(posedge CLK); #1;
    drive(3'd3, 64'hDEAD_BEEF_0123_4567, 64'h0F0F_F0F0_1234_8765, 5'd20, 1'b1);
    push_exp(3'd3, 64'hDEAD_BEEF_0123_4567, 64'h0F0F_F0F0_1234_8765, 5'd20, 1'b1);
    bus.EN = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge CLK); #1;
      if (bus.done) break;
    end
    check("en_hold_done_seen", bus.done, 1'b1);
    bus.EN = 1'b0;
    repeat (80) @(posedge CLK);
    check("en_hold_drained", sb_q.size(), 0);
    sb_q.delete();

    // Randomized operations
    for (int n = 0; n < 40; n++) begin
      issue(3'($urandom_range(0, 7)), pick(), pick(), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    end

    repeat (5) @(posedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
